dram_store_buffer: RTL and testbench

//  Posted-write buffer between the CPU data port (MEM stage) and data memory.
//  CPU stores complete in one cycle into a FIFO; the FIFO drains to memory over a valid/ready write port.
//  CPU loads read memory through a combinational read port, with store-to-load forwarding from the buffer.

---
 rtl/dram_store_buffer.sv | 143 ++++++++++++++
 tb/tb_dram_store_buffer.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dram_store_buffer.sv
// dram_store_buffer: posted-write buffer between the CPU MEM stage and data memory.
// Stores are accepted in one cycle into a circular FIFO. The FIFO drains over a
// valid/ready write port. Loads read memory combinationally and are checked
// against buffered stores.
// Optional feature macro: STORE_FWD_EN
//   defined   -> a load that hits a buffered store returns the youngest matching data
//   undefined -> a load that hits a buffered store stalls until no match remains
module dram_store_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 32,
    parameter int DW    = 32
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     cpu_we_i,
    input  logic                     cpu_re_i,
    input  logic [AW-1:0]            cpu_addr_i,
    input  logic [DW-1:0]            cpu_wdata_i,
    output logic [DW-1:0]            cpu_rdata_o,
    output logic                     cpu_stall_o,
    output logic [AW-1:0]            mem_raddr_o,
    input  logic [DW-1:0]            mem_rdata_i,
    output logic                     mem_wr_valid_o,
    input  logic                     mem_wr_ready_i,
    output logic [AW-1:0]            mem_wr_addr_o,
    output logic [DW-1:0]            mem_wr_data_o,
    output logic                     sb_empty_o,
    output logic [$clog2(DEPTH):0]   sb_count_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    // Entry storage; addresses kept whole so the write port sees the original address
    logic [AW-1:0]    addr_q [DEPTH];
    logic [DW-1:0]    data_q [DEPTH];
    logic [DEPTH-1:0] valid_q, valid_d;

    logic [PW-1:0]    head_q, head_d;
    logic [PW-1:0]    tail_q, tail_d;
    logic [CW-1:0]    count_q, count_d;

    logic             full;
    logic             pop;
    logic             push;
    logic             full_stall;
    logic             load_stall;
    logic [DEPTH-1:0] match;
    logic             hit;

    // Word-granular address compare against every valid entry
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_match
            assign match[gi] = valid_q[gi] &
                               (addr_q[gi][AW-1:2] == cpu_addr_i[AW-1:2]);
        end
    endgenerate

    assign hit            = cpu_re_i & (|match);
    assign full           = (count_q == CW'(DEPTH));
    assign mem_wr_valid_o = (count_q != '0);
    assign mem_wr_addr_o  = addr_q[head_q];
    assign mem_wr_data_o  = data_q[head_q];
    assign pop            = mem_wr_valid_o & mem_wr_ready_i;
    // A full buffer still takes a store when the head leaves in the same cycle
    assign full_stall     = cpu_we_i & full & ~pop;
    assign push           = cpu_we_i & ~full_stall;
    assign cpu_stall_o    = full_stall | load_stall;
    assign mem_raddr_o    = cpu_addr_i;
    assign sb_empty_o     = (count_q == '0);
    assign sb_count_o     = count_q;

`ifdef STORE_FWD_EN
    logic [DW-1:0] fwd_data;
    logic [PW-1:0] age_idx;

    // Walk entries oldest to youngest so the last match (nearest tail) wins;
    // an entry popping this cycle is still valid here, so memory staleness is covered
    always_comb begin
        fwd_data = '0;
        age_idx  = head_q;
        for (int k = 0; k < DEPTH; k++) begin
            age_idx = head_q + PW'(k);
            if (match[age_idx]) begin
                fwd_data = data_q[age_idx];
            end
        end
    end

    assign load_stall  = 1'b0;
    assign cpu_rdata_o = hit ? fwd_data : mem_rdata_i;
`else
    // Without forwarding a matching load waits until every matching store has drained
    assign load_stall  = hit;
    assign cpu_rdata_o = mem_rdata_i;
`endif

    // Next-state for pointers, count and per-entry valid bits
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        valid_d = valid_q;
        if (pop) begin
            valid_d[head_q] = 1'b0;
            head_d          = head_q + PW'(1);
        end
        // Push after pop: when full with a pop, head==tail and the new entry must stay valid
        if (push) begin
            valid_d[tail_q] = 1'b1;
            tail_d          = tail_q + PW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Control state register; reset discards every pending store
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            valid_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            valid_q <= valid_d;
        end
    end

    // Entry payload write; no reset needed since valid bits gate every use
    always_ff @(posedge clk_i) begin
        if (push) begin
            addr_q[tail_q] <= cpu_addr_i;
            data_q[tail_q] <= cpu_wdata_i;
        end
    end

endmodule

// File: tb/tb_dram_store_buffer.sv
// Directed testbench for dram_store_buffer with a bench-side data memory model.
module tb_dram_store_buffer;

    logic        clk;
    logic        rst_n;
    logic        cpu_we;
    logic        cpu_re;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        cpu_stall;
    logic [31:0] mem_raddr;
    logic [31:0] mem_rdata;
    logic        mem_wr_valid;
    logic        mem_wr_ready;
    logic [31:0] mem_wr_addr;
    logic [31:0] mem_wr_data;
    logic        sb_empty;
    logic [2:0]  sb_count;

    int vectors;
    int miscompares;

    logic [31:0] mem_model [1024];
    bit          written   [1024];
    logic [31:0] log_addr [$];
    logic [31:0] log_data [$];

    dram_store_buffer #(.DEPTH(4), .AW(32), .DW(32)) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .cpu_we_i       (cpu_we),
        .cpu_re_i       (cpu_re),
        .cpu_addr_i     (cpu_addr),
        .cpu_wdata_i    (cpu_wdata),
        .cpu_rdata_o    (cpu_rdata),
        .cpu_stall_o    (cpu_stall),
        .mem_raddr_o    (mem_raddr),
        .mem_rdata_i    (mem_rdata),
        .mem_wr_valid_o (mem_wr_valid),
        .mem_wr_ready_i (mem_wr_ready),
        .mem_wr_addr_o  (mem_wr_addr),
        .mem_wr_data_o  (mem_wr_data),
        .sb_empty_o     (sb_empty),
        .sb_count_o     (sb_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Unwritten words read back as 0xA5A5_0000 | word index
    assign mem_rdata = written[mem_raddr[11:2]] ? mem_model[mem_raddr[11:2]]
                                                : (32'hA5A5_0000 | {22'd0, mem_raddr[11:2]});

    // Memory write port: commit on handshake and log in arrival order
    always @(posedge clk) begin
        if (rst_n && mem_wr_valid && mem_wr_ready) begin
            mem_model[mem_wr_addr[11:2]] = mem_wr_data;
            written[mem_wr_addr[11:2]]   = 1'b1;
            log_addr.push_back(mem_wr_addr);
            log_data.push_back(mem_wr_data);
        end
    end

    // Stores and loads must never be requested together
    always @(posedge clk) begin
        if (rst_n) assert (!(cpu_we && cpu_re)) else $error("cpu_we and cpu_re both high");
    end

    // Apply one cycle of inputs just after the falling edge; outputs settle by #1
    task automatic drive(input logic we, input logic re, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic rdy);
        @(negedge clk);
        cpu_we       = we;
        cpu_re       = re;
        cpu_addr     = addr;
        cpu_wdata    = wdata;
        mem_wr_ready = rdy;
        #1;
    endtask

    // Hold ready high until the buffer empties (bounded)
    task automatic drain(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b1);
            if (sb_empty) begin
                ok = 1'b1;
                break;
            end
        end
        drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 32'h300, 32'd0, 1'b0);
        vectors++; if (sb_count !== 3'd0) begin miscompares++; $display("FAIL reset_count got=%0d exp=0", sb_count); end
        vectors++; if (sb_empty !== 1'b1) begin miscompares++; $display("FAIL reset_empty got=%b exp=1", sb_empty); end
        vectors++; if (mem_wr_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid got=%b exp=0", mem_wr_valid); end
        vectors++; if (cpu_stall !== 1'b0) begin miscompares++; $display("FAIL reset_stall got=%b exp=0", cpu_stall); end
        vectors++; if (cpu_rdata !== 32'hA5A5_00C0) begin miscompares++; $display("FAIL reset_rdata got=%h exp=a5a500c0", cpu_rdata); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset_mid_drain;
        int n;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 32'h500 + 32'(4*i), 32'h70 + 32'(i), 1'b0);
            vectors++; if (cpu_stall !== 1'b0) begin miscompares++; $display("FAIL rmd_stall%0d got=%b exp=0", i, cpu_stall); end
        end
        drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
        vectors++; if (sb_count !== 3'd3) begin miscompares++; $display("FAIL rmd_count got=%0d exp=3", sb_count); end
        vectors++; if (mem_wr_addr !== 32'h500) begin miscompares++; $display("FAIL rmd_head got=%h exp=500", mem_wr_addr); end
        n = log_addr.size();
        rst_n = 1'b0;
        #1;
        vectors++; if (sb_count !== 3'd0) begin miscompares++; $display("FAIL rmd_rcount got=%0d exp=0", sb_count); end
        vectors++; if (mem_wr_valid !== 1'b0) begin miscompares++; $display("FAIL rmd_rvalid got=%b exp=0", mem_wr_valid); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b1);
        vectors++; if (log_addr.size() !== n) begin miscompares++; $display("FAIL rmd_nowrite got=%0d exp=%0d", log_addr.size(), n); end
        vectors++; if (sb_empty !== 1'b1) begin miscompares++; $display("FAIL rmd_empty got=%b exp=1", sb_empty); end
        drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
    endtask

    task automatic test_fill_full;
        int base;
        bit ok;
        base = log_addr.size();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0, 32'h400 + 32'(4*i), 32'h10 + 32'(i), 1'b0);
            vectors++; if (cpu_stall !== 1'b0) begin miscompares++; $display("FAIL full_stall%0d got=%b exp=0", i, cpu_stall); end
        end
        drive(1'b1, 1'b0, 32'h410, 32'h14, 1'b0);
        vectors++; if (cpu_stall !== 1'b1) begin miscompares++; $display("FAIL full_5th_stall got=%b exp=1", cpu_stall); end
        vectors++; if (sb_count !== 3'd4) begin miscompares++; $display("FAIL full_count got=%0d exp=4", sb_count); end
        drive(1'b1, 1'b0, 32'h410, 32'h14, 1'b0);
        vectors++; if (cpu_stall !== 1'b1) begin miscompares++; $display("FAIL full_hold_stall got=%b exp=1", cpu_stall); end
        drive(1'b1, 1'b0, 32'h410, 32'h14, 1'b1);
        vectors++; if (cpu_stall !== 1'b0) begin miscompares++; $display("FAIL full_pop_stall got=%b exp=0", cpu_stall); end
        vectors++; if (mem_wr_addr !== 32'h400) begin miscompares++; $display("FAIL full_head got=%h exp=400", mem_wr_addr); end
        drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
        vectors++; if (sb_count !== 3'd4) begin miscompares++; $display("FAIL full_after_count got=%0d exp=4", sb_count); end
        vectors++; if (mem_wr_data !== 32'h11) begin miscompares++; $display("FAIL full_after_head got=%h exp=11", mem_wr_data); end
        drain(ok);
        vectors++; if (ok !== 1'b1) begin miscompares++; $display("FAIL full_drain got=%b exp=1", ok); end
        vectors++; if (log_addr.size() !== base + 5) begin miscompares++; $display("FAIL full_nwrites got=%0d exp=%0d", log_addr.size() - base, 5); end
        for (int i = 0; i < 5 && base + i < log_addr.size(); i++) begin
            vectors++;
            if (log_addr[base+i] !== 32'h400 + 32'(4*i) || log_data[base+i] !== 32'h10 + 32'(i)) begin
                miscompares++;
                $display("FAIL full_order%0d got=%h:%h exp=%h:%h", i, log_addr[base+i], log_data[base+i],
                         32'h400 + 32'(4*i), 32'h10 + 32'(i));
            end
        end
    endtask

    task automatic test_back_to_back;
        int base;
        bit ok;
        base = log_addr.size();
        drive(1'b1, 1'b0, 32'h600, 32'h60, 1'b1);
        vectors++; if (mem_wr_valid !== 1'b0) begin miscompares++; $display("FAIL b2b_nobypass got=%b exp=0", mem_wr_valid); end
        for (int i = 1; i < 4; i++) begin
            drive(1'b1, 1'b0, 32'h600 + 32'(4*i), 32'h60 + 32'(i), 1'b1);
            vectors++;
            if (mem_wr_valid !== 1'b1 || sb_count !== 3'd1 || cpu_stall !== 1'b0) begin
                miscompares++;
                $display("FAIL b2b_step%0d got=v%b c%0d s%b exp=v1 c1 s0", i, mem_wr_valid, sb_count, cpu_stall);
            end
        end
        drain(ok);
        vectors++; if (log_addr.size() !== base + 4) begin miscompares++; $display("FAIL b2b_nwrites got=%0d exp=4", log_addr.size() - base); end
        for (int i = 0; i < 4 && base + i < log_addr.size(); i++) begin
            vectors++;
            if (log_addr[base+i] !== 32'h600 + 32'(4*i)) begin
                miscompares++;
                $display("FAIL b2b_order%0d got=%h exp=%h", i, log_addr[base+i], 32'h600 + 32'(4*i));
            end
        end
    endtask

    task automatic test_ordering;
        int base;
        bit done;
        logic [31:0] exp_a [3];
        logic [31:0] exp_d [3];
        exp_a[0] = 32'h100; exp_d[0] = 32'd1;
        exp_a[1] = 32'h104; exp_d[1] = 32'd2;
        exp_a[2] = 32'h100; exp_d[2] = 32'd3;
        base = log_addr.size();
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, exp_a[i], exp_d[i], 1'b0);
        done = 1'b0;
        for (int i = 0; i < 20; i++) begin
            drive(1'b0, 1'b0, 32'd0, 32'd0, (i % 2 == 0) ? 1'b1 : 1'b0);
            if (sb_empty) begin
                done = 1'b1;
                break;
            end
        end
        drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
        vectors++; if (done !== 1'b1) begin miscompares++; $display("FAIL ord_drain got=%b exp=1", done); end
        vectors++; if (log_addr.size() !== base + 3) begin miscompares++; $display("FAIL ord_nwrites got=%0d exp=3", log_addr.size() - base); end
        for (int i = 0; i < 3 && base + i < log_addr.size(); i++) begin
            vectors++;
            if (log_addr[base+i] !== exp_a[i] || log_data[base+i] !== exp_d[i]) begin
                miscompares++;
                $display("FAIL ord_seq%0d got=%h:%h exp=%h:%h", i, log_addr[base+i], log_data[base+i], exp_a[i], exp_d[i]);
            end
        end
        vectors++; if (mem_model[10'h40] !== 32'd3) begin miscompares++; $display("FAIL ord_mem100 got=%h exp=3", mem_model[10'h40]); end
        vectors++; if (mem_model[10'h41] !== 32'd2) begin miscompares++; $display("FAIL ord_mem104 got=%h exp=2", mem_model[10'h41]); end
    endtask

`ifdef STORE_FWD_EN
    task automatic test_forwarding;
        bit ok;
        drive(1'b1, 1'b0, 32'h200, 32'hAA, 1'b0);
        drive(1'b1, 1'b0, 32'h200, 32'hBB, 1'b0);
        drive(1'b1, 1'b0, 32'h208, 32'hCC, 1'b0);
        drive(1'b0, 1'b1, 32'h202, 32'd0, 1'b0);
        vectors++; if (cpu_rdata !== 32'hBB) begin miscompares++; $display("FAIL fwd_young got=%h exp=bb", cpu_rdata); end
        vectors++; if (cpu_stall !== 1'b0) begin miscompares++; $display("FAIL fwd_stall got=%b exp=0", cpu_stall); end
        drive(1'b0, 1'b1, 32'h208, 32'd0, 1'b0);
        vectors++; if (cpu_rdata !== 32'hCC) begin miscompares++; $display("FAIL fwd_208 got=%h exp=cc", cpu_rdata); end
        drive(1'b0, 1'b1, 32'h300, 32'd0, 1'b0);
        vectors++; if (cpu_rdata !== 32'hA5A5_00C0) begin miscompares++; $display("FAIL fwd_miss got=%h exp=a5a500c0", cpu_rdata); end
        drain(ok);
        vectors++; if (mem_model[10'h80] !== 32'hBB) begin miscompares++; $display("FAIL fwd_mem200 got=%h exp=bb", mem_model[10'h80]); end
    endtask
`else
    task automatic test_no_forwarding;
        drive(1'b1, 1'b0, 32'h200, 32'hAA, 1'b0);
        drive(1'b0, 1'b1, 32'h200, 32'd0, 1'b0);
        vectors++; if (cpu_stall !== 1'b1) begin miscompares++; $display("FAIL nofwd_stall got=%b exp=1", cpu_stall); end
        drive(1'b0, 1'b1, 32'h200, 32'd0, 1'b0);
        vectors++; if (cpu_stall !== 1'b1) begin miscompares++; $display("FAIL nofwd_hold got=%b exp=1", cpu_stall); end
        vectors++; if (cpu_rdata !== 32'hA5A5_0080) begin miscompares++; $display("FAIL nofwd_rdmem got=%h exp=a5a50080", cpu_rdata); end
        drive(1'b0, 1'b1, 32'h208, 32'd0, 1'b0);
        vectors++; if (cpu_stall !== 1'b0) begin miscompares++; $display("FAIL nofwd_miss_stall got=%b exp=0", cpu_stall); end
        drive(1'b0, 1'b1, 32'h200, 32'd0, 1'b1);
        vectors++; if (cpu_stall !== 1'b1) begin miscompares++; $display("FAIL nofwd_popcyc got=%b exp=1", cpu_stall); end
        drive(1'b0, 1'b1, 32'h200, 32'd0, 1'b0);
        vectors++; if (cpu_stall !== 1'b0) begin miscompares++; $display("FAIL nofwd_release got=%b exp=0", cpu_stall); end
        vectors++; if (cpu_rdata !== 32'hAA) begin miscompares++; $display("FAIL nofwd_rdata got=%h exp=aa", cpu_rdata); end
        drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
    endtask
`endif

    task automatic test_pop_during_load;
        drive(1'b1, 1'b0, 32'h40, 32'h55, 1'b0);
        drive(1'b0, 1'b1, 32'h40, 32'd0, 1'b1);
`ifdef STORE_FWD_EN
        vectors++; if (cpu_rdata !== 32'h55) begin miscompares++; $display("FAIL pdl_fwd got=%h exp=55", cpu_rdata); end
        vectors++; if (cpu_stall !== 1'b0) begin miscompares++; $display("FAIL pdl_stall got=%b exp=0", cpu_stall); end
`else
        vectors++; if (cpu_stall !== 1'b1) begin miscompares++; $display("FAIL pdl_stall got=%b exp=1", cpu_stall); end
`endif
        drive(1'b0, 1'b1, 32'h40, 32'd0, 1'b0);
        vectors++; if (cpu_stall !== 1'b0) begin miscompares++; $display("FAIL pdl_after_stall got=%b exp=0", cpu_stall); end
        vectors++; if (cpu_rdata !== 32'h55) begin miscompares++; $display("FAIL pdl_after_rdata got=%h exp=55", cpu_rdata); end
        vectors++; if (sb_empty !== 1'b1) begin miscompares++; $display("FAIL pdl_empty got=%b exp=1", sb_empty); end
        drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
    endtask

    initial begin
        vectors      = 0;
        miscompares  = 0;
        rst_n        = 1'b0;
        cpu_we       = 1'b0;
        cpu_re       = 1'b0;
        cpu_addr     = 32'd0;
        cpu_wdata    = 32'd0;
        mem_wr_ready = 1'b0;
        test_reset();
        test_reset_mid_drain();
        test_fill_full();
        test_back_to_back();
        test_ordering();
`ifdef STORE_FWD_EN
        test_forwarding();
`else
        test_no_forwarding();
`endif
        test_pop_during_load();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
